// File: rtl/int_pkg.sv
// -----------------------------------------------------------------------------
// int_pkg
// Shared definitions for the interrupt-controller register bridge:
//   - FSM state encoding for the bridge sequencer
//   - request size encoding (32-bit / 64-bit access)
//   - slice data width and host bus data width
// -----------------------------------------------------------------------------
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_LO = 2'd1,
        ST_ACC_HI = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic SIZE_32 = 1'b0;
    localparam logic SIZE_64 = 1'b1;

    localparam int SLICE_W = 32;
    localparam int BUS_W   = 64;

endpackage : int_pkg

// File: rtl/int_reg_bridge_if.sv
// -----------------------------------------------------------------------------
// int_reg_bridge_if
// Core-side request/response channel of the register bridge.
//   req_*  : valid/ready load/store request (wr, size, byte addr, store data)
//   resp_* : valid/ready response (load data, decode error)
// Modports:
//   master : the core / LSU side that issues requests and consumes responses
//   slave  : the bridge side that accepts requests and produces responses
// -----------------------------------------------------------------------------
interface int_reg_bridge_if #(
    parameter int ADDR_W = 12
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic              req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface : int_reg_bridge_if

// File: rtl/int_reg_addr_dec.sv
// -----------------------------------------------------------------------------
// int_reg_addr_dec
// Combinational address decoder for the register bridge.
//   size, addr : incoming request size and byte address (checked at accept)
//   err        : misaligned or out-of-range access
//   idx        : word index of the request, addr[ADDR_W-1:2]
//   sel_en     : enables the slice select (bridge is in an access cycle)
//   sel_idx    : slice index to select this cycle
//   sel        : one-hot slice select, all zero when sel_en is low
// -----------------------------------------------------------------------------
module int_reg_addr_dec
    import int_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 12
) (
    input  logic                size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                sel_en,
    input  logic [ADDR_W-3:0]   sel_idx,
    output logic                err,
    output logic [ADDR_W-3:0]   idx,
    output logic [NUM_REGS-1:0] sel
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int IDX_W1 = IDX_W + 1;

    localparam logic [IDX_W1-1:0] NUM_L = IDX_W1'(NUM_REGS);

    logic              misaligned;
    logic              out_of_range;
    logic [IDX_W1-1:0] idx_ext;

    assign idx     = addr[ADDR_W-1:2];
    assign idx_ext = {1'b0, idx};

    // A 64-bit access must be 8-byte aligned and needs the next slice to exist.
    assign misaligned   = (size == SIZE_64) ? (addr[2:0] != 3'b000)
                                            : (addr[1:0] != 2'b00);
    assign out_of_range = (idx_ext >= NUM_L) ||
                          ((size == SIZE_64) && ((idx_ext + IDX_W1'(1)) >= NUM_L));
    assign err          = misaligned || out_of_range;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = sel_en && (sel_idx == IDX_W'(i));
        end
    end

endmodule : int_reg_addr_dec

// File: rtl/int_reg_bridge.sv
// -----------------------------------------------------------------------------
// int_reg_bridge
// Host-side initiator for the interrupt controller register slices.
// Accepts 32/64-bit MMIO loads/stores, drives the shared slice bus one slice
// per cycle, gathers read data and returns it on a valid/ready response.
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : request/response channel (slave modport)
//   reg_en     : slice access strobe (ACC_LO / ACC_HI only)
//   reg_wr     : slice write qualifier
//   reg_wdata  : slice write data, [31:0] meaningful, [63:32] always 0
//   reg_sel    : one-hot slice select
//   reg_rdata  : concatenated slice outputs, slice i at [32*i+31:32*i]
// -----------------------------------------------------------------------------
module int_reg_bridge
    import int_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 12
) (
    input  logic                        clk,
    input  logic                        rstn,
    int_reg_bridge_if.slave             bus,
    output logic                        reg_en,
    output logic                        reg_wr,
    output logic [BUS_W-1:0]            reg_wdata,
    output logic [NUM_REGS-1:0]         reg_sel,
    input  logic [NUM_REGS*SLICE_W-1:0] reg_rdata
);

    localparam int IDX_W = ADDR_W - 2;

    state_t             state;
    state_t             state_nxt;

    logic               wr_q;
    logic               size_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BUS_W-1:0]   wdata_q;
    logic [BUS_W-1:0]   rdata_q;
    logic               err_q;

    logic               req_fire;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;
    logic               sel_en;
    logic [IDX_W-1:0]   sel_idx;
    logic [SLICE_W-1:0] slice_rd;

    assign req_fire = bus.req_valid && bus.req_ready;

    int_reg_addr_dec #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .size     (bus.req_size),
        .addr     (bus.req_addr),
        .sel_en   (sel_en),
        .sel_idx  (sel_idx),
        .err      (dec_err),
        .idx      (dec_idx),
        .sel      (reg_sel)
    );

    // reg_sel is one-hot, so OR-ing the selected slices is a plain mux.
    always_comb begin
        slice_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_sel[i]) begin
                slice_rd = slice_rd | reg_rdata[i*SLICE_W +: SLICE_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    state_nxt = dec_err ? ST_RESP : ST_ACC_LO;
                end
            end
            ST_ACC_LO: begin
                state_nxt = (size_q == SIZE_64) ? ST_ACC_HI : ST_RESP;
            end
            ST_ACC_HI: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic. req_ready is gated by rstn so it reads 0 while reset is held.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        reg_en         = 1'b0;
        reg_wr         = 1'b0;
        reg_wdata      = '0;
        sel_en         = 1'b0;
        sel_idx        = idx_q;
        case (state)
            ST_IDLE: begin
                bus.req_ready = rstn;
            end
            ST_ACC_LO: begin
                reg_en    = 1'b1;
                reg_wr    = wr_q;
                reg_wdata = {32'b0, wdata_q[31:0]};
                sel_en    = 1'b1;
                sel_idx   = idx_q;
            end
            ST_ACC_HI: begin
                reg_en    = 1'b1;
                reg_wr    = wr_q;
                reg_wdata = {32'b0, wdata_q[63:32]};
                sel_en    = 1'b1;
                sel_idx   = idx_q + IDX_W'(1);
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
            end
            default: begin
                bus.req_ready = 1'b0;
            end
        endcase
    end

    // Request latches and read-data capture. rdata is cleared on accept so
    // stores and errors respond with zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_32;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_fire) begin
                wr_q    <= bus.req_wr;
                size_q  <= bus.req_size;
                idx_q   <= dec_idx;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= dec_err;
            end else if (state == ST_ACC_LO && !wr_q) begin
                rdata_q[31:0] <= slice_rd;
            end else if (state == ST_ACC_HI && !wr_q) begin
                rdata_q[63:32] <= slice_rd;
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule : int_reg_bridge

// File: tb/tb_int_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_int_reg_bridge
// Self-checking bench for int_reg_bridge: directed vector table, hand-written
// multi-cycle sequences (response hold, back-to-back, reset mid-access) and
// randomized traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_int_reg_bridge;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 12;

    logic                   clk;
    logic                   rstn;
    logic                   reg_en;
    logic                   reg_wr;
    logic [63:0]            reg_wdata;
    logic [NUM_REGS-1:0]    reg_sel;
    logic [NUM_REGS*32-1:0] reg_rdata;

    int_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    int_reg_bridge #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .reg_en    (reg_en),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice array: flops written from the slice bus, not reset by rstn.
    logic [31:0] slices [NUM_REGS] = '{default: 32'h0};

    always @(posedge clk) begin
        if (reg_en && reg_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_sel[i]) slices[i] <= reg_wdata[31:0];
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_rdata[i*32 +: 32] = slices[i];
    end

    // Reference model: expected slice contents per transaction.
    logic [31:0] ref_mem [NUM_REGS] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input logic wr, input logic size, input logic [11:0] addr,
                         input logic [63:0] wdata,
                         output logic err, output logic [63:0] rd, output int lat);
        int idx;
        idx = int'(addr) / 4;
        err = (size ? (int'(addr) % 8 != 0) : (int'(addr) % 4 != 0)) ||
              (idx >= NUM_REGS) || (size && (idx + 1 >= NUM_REGS));
        rd  = 64'h0;
        lat = err ? 1 : (size ? 3 : 2);
        if (!err) begin
            if (wr) begin
                ref_mem[idx] = wdata[31:0];
                if (size) ref_mem[idx+1] = wdata[63:32];
            end else begin
                rd = size ? {ref_mem[idx+1], ref_mem[idx]} : {32'h0, ref_mem[idx]};
            end
        end
    endtask

    // Results of the last transaction.
    logic [63:0]         r_rdata;
    logic                r_err;
    int                  r_lat;
    int                  r_acc_wait;
    logic                r_en_seen;
    logic [NUM_REGS-1:0] r_lo_sel;
    logic                r_lo_wr;
    logic                r_bad_sel;
    logic                r_bad_hold;
    logic                r_timeout;

    // Called just after a rising edge; returns just after the response handshake edge.
    task automatic run_txn(input logic wr, input logic size, input logic [11:0] addr,
                           input logic [63:0] wdata, input int hold);
        logic rdy;
        int   n;
        r_rdata = '0; r_err = 1'b0; r_lat = 0; r_en_seen = 1'b0; r_lo_sel = '0;
        r_lo_wr = 1'b0; r_bad_sel = 1'b0; r_bad_hold = 1'b0; r_timeout = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (!rdy) n++;
        end
        r_acc_wait    = n;
        bus.req_valid = 1'b0;
        if (!rdy) begin
            r_timeout = 1'b1;
            return;
        end
        while (1) begin
            @(negedge clk);
            r_lat++;
            if (bus.req_ready) r_bad_hold = 1'b1;
            if (reg_en) begin
                if (!r_en_seen) begin
                    r_lo_sel = reg_sel;
                    r_lo_wr  = reg_wr;
                end
                r_en_seen = 1'b1;
                if ($countones(reg_sel) != 1) r_bad_sel = 1'b1;
            end else if (reg_sel != '0) begin
                r_bad_sel = 1'b1;
            end
            if (bus.resp_valid) break;
            if (r_lat >= 20) begin
                r_timeout = 1'b1;
                return;
            end
        end
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== r_rdata ||
                bus.resp_err !== r_err || bus.req_ready || reg_en) r_bad_hold = 1'b1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    typedef struct {
        logic                wr;
        logic                size;
        logic [11:0]         addr;
        logic [63:0]         wdata;
        logic                exp_err;
        logic [63:0]         exp_rdata;
        int                  exp_lat;
        logic [NUM_REGS-1:0] exp_lo_sel;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m_err;
        logic [63:0] m_rd;
        int          m_lat;
        logic        rw, sz;
        logic [11:0] ad;
        logic [63:0] wd;

        vecs[0]  = '{1'b1, 1'b0, 12'h008, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0, 2, 32'h0000_0004};
        vecs[1]  = '{1'b1, 1'b0, 12'h010, 64'h0000_0000_1111_1111, 1'b0, 64'h0, 2, 32'h0000_0010};
        vecs[2]  = '{1'b1, 1'b0, 12'h014, 64'h0000_0000_2222_2222, 1'b0, 64'h0, 2, 32'h0000_0020};
        vecs[3]  = '{1'b0, 1'b1, 12'h010, 64'h0, 1'b0, 64'h2222_2222_1111_1111, 3, 32'h0000_0010};
        vecs[4]  = '{1'b0, 1'b0, 12'h006, 64'h0, 1'b1, 64'h0, 1, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 12'h004, 64'h0, 1'b1, 64'h0, 1, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 12'h080, 64'h0, 1'b1, 64'h0, 1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 12'h07C, 64'h0, 1'b1, 64'h0, 1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 12'h07C, 64'h0000_0000_CAFE_F00D, 1'b0, 64'h0, 2, 32'h8000_0000};
        vecs[9]  = '{1'b0, 1'b0, 12'h07C, 64'h0, 1'b0, 64'h0000_0000_CAFE_F00D, 2, 32'h8000_0000};
        vecs[10] = '{1'b0, 1'b0, 12'h008, 64'h0, 1'b0, 64'h0000_0000_DEAD_BEEF, 2, 32'h0000_0004};
        vecs[11] = '{1'b1, 1'b1, 12'h018, 64'h0BAD_C0DE_1234_5678, 1'b0, 64'h0, 3, 32'h0000_0040};
        vecs[12] = '{1'b0, 1'b1, 12'h018, 64'h0, 1'b0, 64'h0BAD_C0DE_1234_5678, 3, 32'h0000_0040};
        vecs[13] = '{1'b1, 1'b0, 12'h00A, 64'h0000_0000_5555_AAAA, 1'b1, 64'h0, 1, 32'h0};

        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_size   = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        rstn = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("reset_req_ready",  {63'h0, bus.req_ready},  64'h0);
        chk("reset_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        chk("reset_resp_rdata", bus.resp_rdata,          64'h0);
        chk("reset_resp_err",   {63'h0, bus.resp_err},   64'h0);
        chk("reset_reg_bus",    {reg_wdata[31:0] | reg_wdata[63:32], reg_sel}, 64'h0);
        chk("reset_reg_en_wr",  {62'h0, reg_en, reg_wr}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", {63'h0, bus.req_ready}, 64'h1);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int v = 0; v < 14; v++) begin
            run_txn(vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata, 0);
            model(vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata, m_err, m_rd, m_lat);
            chk($sformatf("vec%0d_timeout", v), {63'h0, r_timeout}, 64'h0);
            chk($sformatf("vec%0d_err", v),     {63'h0, r_err},     {63'h0, vecs[v].exp_err});
            chk($sformatf("vec%0d_rdata", v),   r_rdata,            vecs[v].exp_rdata);
            chk($sformatf("vec%0d_latency", v), 64'(r_lat),         64'(vecs[v].exp_lat));
            chk($sformatf("vec%0d_lo_sel", v),  64'(r_lo_sel),      64'(vecs[v].exp_lo_sel));
            chk($sformatf("vec%0d_reg_en", v),  {63'h0, r_en_seen}, {63'h0, !vecs[v].exp_err});
            chk($sformatf("vec%0d_sel_onehot", v), {63'h0, r_bad_sel}, 64'h0);
        end
        chk("store_lo_reg_wr", {63'h0, vecs[0].wr}, {63'h0, 1'b1});
        chk("slice2_value",  {32'h0, slices[2]},  64'h0000_0000_DEAD_BEEF);
        chk("slice2_misaligned_store_untouched", {32'h0, slices[2]}, {32'h0, ref_mem[2]});

        // 32-bit store: reg_wr seen in ACC_LO
        run_txn(1'b1, 1'b0, 12'h00C, 64'h0000_0000_A5A5_0001, 0);
        model(1'b1, 1'b0, 12'h00C, 64'h0000_0000_A5A5_0001, m_err, m_rd, m_lat);
        chk("store_acc_lo_reg_wr",  {63'h0, r_lo_wr}, 64'h1);
        chk("store_acc_lo_reg_sel", 64'(r_lo_sel),    64'h8);

        // Response held off for 5 cycles, then back-to-back request
        run_txn(1'b0, 1'b1, 12'h010, 64'h0, 5);
        chk("hold_rdata",  r_rdata,              64'h2222_2222_1111_1111);
        chk("hold_stable", {63'h0, r_bad_hold},  64'h0);
        run_txn(1'b0, 1'b0, 12'h008, 64'h0, 0);
        chk("b2b_accept_wait", 64'(r_acc_wait), 64'h0);
        chk("b2b_rdata",       r_rdata,         64'h0000_0000_DEAD_BEEF);
        chk("b2b_latency",     64'(r_lat),      64'h2);

        // Reset asserted during ACC_HI of a 64-bit store to slices 20/21
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_size  = 1'b1;
        bus.req_addr  = 12'h050;
        bus.req_wdata = 64'hAAAA_5555_1234_5678;
        @(negedge clk);
        chk("rst_mid_ready", {63'h0, bus.req_ready}, 64'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_acc_hi_sel", 64'(reg_sel), 64'(32'h0020_0000));
        rstn = 1'b0;
        #1;
        chk("rst_mid_reg_en",     {63'h0, reg_en},       64'h0);
        chk("rst_mid_reg_sel",    64'(reg_sel),          64'h0);
        chk("rst_mid_reg_wdata",  reg_wdata,             64'h0);
        chk("rst_mid_reg_wr",     {63'h0, reg_wr},       64'h0);
        chk("rst_mid_req_ready",  {63'h0, bus.req_ready}, 64'h0);
        chk("rst_mid_resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        ref_mem[20] = 32'h1234_5678;
        chk("rst_mid_slice20", {32'h0, slices[20]}, 64'h1234_5678);
        chk("rst_mid_slice21", {32'h0, slices[21]}, 64'h0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            rw = 1'($urandom_range(0, 1));
            sz = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ad = 12'($urandom_range(0, 4095));
                1:       ad = 12'($urandom_range(0, 40) * 4);
                default: ad = sz ? 12'($urandom_range(0, 16) * 8) : 12'($urandom_range(0, 33) * 4);
            endcase
            wd = {32'($urandom), 32'($urandom)};
            run_txn(rw, sz, ad, wd, int'($urandom_range(0, 2)));
            model(rw, sz, ad, wd, m_err, m_rd, m_lat);
            chk($sformatf("rnd%0d_timeout", t), {63'h0, r_timeout}, 64'h0);
            chk($sformatf("rnd%0d_err", t),     {63'h0, r_err},     {63'h0, m_err});
            chk($sformatf("rnd%0d_rdata", t),   r_rdata,            m_rd);
            chk($sformatf("rnd%0d_latency", t), 64'(r_lat),         64'(m_lat));
            chk($sformatf("rnd%0d_reg_en", t),  {63'h0, r_en_seen}, {63'h0, !m_err});
            chk($sformatf("rnd%0d_bus", t),     {62'h0, r_bad_sel, r_bad_hold}, 64'h0);
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            chk($sformatf("final_slice%0d", i), {32'h0, slices[i]}, {32'h0, ref_mem[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_int_reg_bridge
